apb_arb_master: RTL and testbench

- APB requester-side controller that shares one APB bus between NUM_REQ local requesters and sequences the IDLE -> SETUP -> ACCESS protocol toward the APB slave.
- Round-robin arbitration; one transfer in flight at a time.
- Per-requester single-cycle response pulses carrying read data and error status.
- ACCESS-phase watchdog terminates hung transfers with an error.

---
 rtl/apb_arb_master.sv | 185 ++++++++++++++++++
 tb/tb_apb_arb_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
// Round-robin arbiter sharing one APB bus between NUM_REQ requesters.
// It runs one IDLE/SETUP/ACCESS transfer at a time and has an ACCESS-phase watchdog.
module apb_arb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [PW-1:0]           rr_r, rr_nxt_s;
    logic [PW-1:0]           owner_r, owner_nxt_s;
    logic [CW-1:0]           cnt_r, cnt_nxt_s;
    logic                    psel_nxt_s, penable_nxt_s, pwrite_nxt_s;
    logic [ADDR_WIDTH-1:0]   paddr_nxt_s;
    logic [DATA_WIDTH-1:0]   pwdata_nxt_s;
    logic [NUM_REQ-1:0]      rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt_s;
    logic                    rsp_err_nxt_s;
    logic                    grant_found_s;
    logic [PW-1:0]           grant_idx_s;

    // Requester index ptr+off wrapped into 0..NUM_REQ-1 (both operands already in range).
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] ptr, input int off);
        int sum;
        sum = int'(ptr) + off;
        if (sum >= NUM_REQ) begin
            return PW'(sum - NUM_REQ);
        end else begin
            return PW'(sum);
        end
    endfunction

    // Round-robin search: first valid requester at or after the rr pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = rr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx_s   = (!grant_found_s && req_valid[rr_index(rr_r, i)]) ? rr_index(rr_r, i) : grant_idx_s;
            grant_found_s = grant_found_s | req_valid[rr_index(rr_r, i)];
        end
    end

    // Grant is only offered while the bus is idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!preset && (state_r == IDLE) && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        rr_nxt_s        = rr_r;
        owner_nxt_s     = owner_r;
        cnt_nxt_s       = cnt_r;
        psel_nxt_s      = psel;
        penable_nxt_s   = penable;
        pwrite_nxt_s    = pwrite;
        paddr_nxt_s     = paddr;
        pwdata_nxt_s    = pwdata;
        rsp_valid_nxt_s = '0;
        rsp_rdata_nxt_s = rsp_rdata;
        rsp_err_nxt_s   = rsp_err;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    owner_nxt_s   = grant_idx_s;
                    rr_nxt_s      = rr_index(grant_idx_s, 1);
                    pwrite_nxt_s  = req_write[grant_idx_s];
                    paddr_nxt_s   = req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_nxt_s  = req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b0;
                    state_nxt_s   = SETUP;
                end else begin
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    pwrite_nxt_s  = 1'b0;
                end
            end
            SETUP: begin
                penable_nxt_s = 1'b1;
                cnt_nxt_s     = '0;
                state_nxt_s   = ACCESS;
            end
            ACCESS: begin
                // pready wins over the watchdog when both land in the same cycle.
                if (pready) begin
                    rsp_valid_nxt_s          = '0;
                    rsp_valid_nxt_s[owner_r] = 1'b1;
                    rsp_err_nxt_s            = pslverr;
                    rsp_rdata_nxt_s          = pwrite ? '0 : prdata;
                    psel_nxt_s               = 1'b0;
                    penable_nxt_s            = 1'b0;
                    pwrite_nxt_s             = 1'b0;
                    state_nxt_s              = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_r == LAST_CNT)) begin
                    rsp_valid_nxt_s          = '0;
                    rsp_valid_nxt_s[owner_r] = 1'b1;
                    rsp_err_nxt_s            = 1'b1;
                    rsp_rdata_nxt_s          = '0;
                    psel_nxt_s               = 1'b0;
                    penable_nxt_s            = 1'b0;
                    pwrite_nxt_s             = 1'b0;
                    state_nxt_s              = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                psel_nxt_s    = 1'b0;
                penable_nxt_s = 1'b0;
                pwrite_nxt_s  = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State register and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r   <= IDLE;
            rr_r      <= '0;
            owner_r   <= '0;
            cnt_r     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rr_r      <= rr_nxt_s;
            owner_r   <= owner_nxt_s;
            cnt_r     <= cnt_nxt_s;
            psel      <= psel_nxt_s;
            penable   <= penable_nxt_s;
            pwrite    <= pwrite_nxt_s;
            paddr     <= paddr_nxt_s;
            pwdata    <= pwdata_nxt_s;
            rsp_valid <= rsp_valid_nxt_s;
            rsp_rdata <= rsp_rdata_nxt_s;
            rsp_err   <= rsp_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: directed scenarios plus randomized transfers
// compared against a last-granted round-robin model and latency formulas.
module tb_apb_arb_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 2;
    localparam int TO = 4;

    logic            pclk = 1'b0;
    logic            preset;
    logic [NR-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic            rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]   paddr;

    int total = 0;
    int bad = 0;
    int model_last = NR - 1;
    int slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic slv_err = 1'b0;
    int acc_cnt;

    always #5 pclk = ~pclk;

    apb_arb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr));

    // Slave model: holds pready low for slv_waits ACCESS cycles.
    always @(posedge pclk or posedge preset) begin
        if (preset) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign pready  = psel && penable && (acc_cnt >= slv_waits);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    function automatic int model_pick(input logic [NR-1:0] vm);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (model_last + k) % NR;
            if (vm[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_lat(input int w);
        return 2 + (((w + 1) < TO) ? (w + 1) : TO);
    endfunction

    // Runs one transfer from posedge+1; returns at posedge+1 of the response cycle.
    task automatic drive_xfer(input logic [NR-1:0] vm, input logic [NR-1:0] wv,
                              input logic [NR*AW-1:0] av, input logic [NR*DW-1:0] dv,
                              input int waits, input logic [DW-1:0] rd, input logic err,
                              output logic [NR-1:0] rdy, output int lat, output int acc,
                              output logic [1:0] s_selen, output logic [AW-1:0] s_addr,
                              output logic s_wr, output logic [DW-1:0] s_wdata,
                              output logic [NR-1:0] r_v, output logic [DW-1:0] r_d, output logic r_e);
        slv_waits = waits; slv_rdata = rd; slv_err = err;
        req_valid = vm; req_write = wv; req_addr = av; req_wdata = dv;
        #1 rdy = req_ready;
        @(posedge pclk); #1;
        req_valid = '0;
        lat = -1; acc = 0; s_selen = '0; s_addr = '0; s_wr = 1'b0; s_wdata = '0;
        r_v = '0; r_d = '0; r_e = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) begin
                s_selen = {psel, penable}; s_addr = paddr; s_wr = pwrite; s_wdata = pwdata;
            end
            if (psel && penable) acc++;
            if (rsp_valid != '0) begin
                lat = c; r_v = rsp_valid; r_d = rsp_rdata; r_e = rsp_err;
                break;
            end
            @(posedge pclk); #1;
        end
    endtask

    task automatic test_reset();
        preset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        #1 preset = 1'b1;
        req_valid = 2'b11;
        #2;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
        total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_apb got=%b want=000", {psel, penable, pwrite}); end
        total++; if ({paddr, pwdata} !== '0) begin bad++; $display("FAIL reset_addr_data got=%h want=0", {paddr, pwdata}); end
        total++; if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_valid, rsp_rdata, rsp_err}); end
        repeat (2) @(posedge pclk);
        #1;
        total++; if ({req_ready, psel} !== 3'b000) begin bad++; $display("FAIL reset_hold got=%b want=000", {req_ready, psel}); end
        req_valid = '0;
        preset = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic test_single_write();
        logic [NR-1:0] rdy, rv; int lat, acc; logic [1:0] se; logic [AW-1:0] sa;
        logic sw, re; logic [DW-1:0] sd, rdd;
        drive_xfer(2'b01, 2'b01, {8'h00, 8'h10}, {32'h0, 32'hDEADBEEF}, 0, 32'h0, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        model_last = 0;
        total++; if (rdy !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b want=01", rdy); end
        total++; if (se !== 2'b10) begin bad++; $display("FAIL wr_setup_selen got=%b want=10", se); end
        total++; if ({sa, sw, sd} !== {8'h10, 1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_setup_bus got=%h want=%h", {sa, sw, sd}, {8'h10, 1'b1, 32'hDEADBEEF}); end
        total++; if (lat !== 3 || acc !== 1) begin bad++; $display("FAIL wr_latency got=%0d/%0d want=3/1", lat, acc); end
        total++; if ({rv, re} !== 3'b010) begin bad++; $display("FAIL wr_rsp got=%b want=010", {rv, re}); end
        @(posedge pclk); #1;
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_pulse_width got=%b want=00", rsp_valid); end
    endtask

    task automatic test_read_wait();
        logic [NR-1:0] rdy, rv; int lat, acc; logic [1:0] se; logic [AW-1:0] sa;
        logic sw, re; logic [DW-1:0] sd, rdd;
        drive_xfer(2'b10, 2'b00, {8'h04, 8'h00}, '0, 2, 32'h12345678, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        model_last = 1;
        total++; if (rdy !== 2'b10) begin bad++; $display("FAIL rd_grant got=%b want=10", rdy); end
        total++; if ({sa, sw} !== {8'h04, 1'b0}) begin bad++; $display("FAIL rd_setup got=%h want=%h", {sa, sw}, {8'h04, 1'b0}); end
        total++; if (lat !== 5 || acc !== 3) begin bad++; $display("FAIL rd_wait_cycles got=%0d/%0d want=5/3", lat, acc); end
        total++; if ({rv, re} !== 3'b100) begin bad++; $display("FAIL rd_rsp got=%b want=100", {rv, re}); end
        total++; if (rdd !== 32'h12345678) begin bad++; $display("FAIL rd_data got=%h want=12345678", rdd); end
    endtask

    task automatic test_slave_error();
        logic [NR-1:0] rdy, rv; int lat, acc; logic [1:0] se; logic [AW-1:0] sa;
        logic sw, re; logic [DW-1:0] sd, rdd;
        drive_xfer(2'b01, 2'b01, {8'h00, 8'h20}, {32'h0, 32'h0BADF00D}, 1, 32'h55AA55AA, 1'b1,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        model_last = 0;
        total++; if ({rdy, rv} !== 4'b0101) begin bad++; $display("FAIL err_owner got=%b want=0101", {rdy, rv}); end
        total++; if ({re, rdd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL err_rsp got=%h want=%h", {re, rdd}, {1'b1, 32'h0}); end
        total++; if (lat !== 4) begin bad++; $display("FAIL err_latency got=%0d want=4", lat); end
        @(posedge pclk); #1;
        total++; if ({rsp_valid, rsp_err} !== 3'b001) begin bad++; $display("FAIL err_hold got=%b want=001", {rsp_valid, rsp_err}); end
        drive_xfer(2'b10, 2'b00, {8'h30, 8'h00}, '0, 0, 32'hA5A50001, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        model_last = 1;
        total++; if ({rv, re, rdd} !== {2'b10, 1'b0, 32'hA5A50001}) begin bad++; $display("FAIL err_clear got=%h want=%h", {rv, re, rdd}, {2'b10, 1'b0, 32'hA5A50001}); end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rdy, rv; int lat, acc; logic [1:0] se; logic [AW-1:0] sa;
        logic sw, re; logic [DW-1:0] sd, rdd; int busy;
        drive_xfer(2'b01, 2'b00, {8'h00, 8'h44}, '0, 1000, 32'hFFFF0000, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        model_last = 0;
        total++; if (acc !== TO) begin bad++; $display("FAIL to_access_cycles got=%0d want=%0d", acc, TO); end
        total++; if (lat !== TO + 2) begin bad++; $display("FAIL to_latency got=%0d want=%0d", lat, TO + 2); end
        total++; if ({rv, re, rdd} !== {2'b01, 1'b1, 32'h0}) begin bad++; $display("FAIL to_rsp got=%h want=%h", {rv, re, rdd}, {2'b01, 1'b1, 32'h0}); end
        busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge pclk); #1;
            if (psel || penable || (rsp_valid != '0)) busy++;
        end
        total++; if (busy !== 0) begin bad++; $display("FAIL to_bus_idle got=%0d want=0", busy); end
        slv_waits = 0;
    endtask

    task automatic test_back_to_back();
        int grants[$], gcyc[$], rsps[$];
        int overlap, g, exp_g;
        overlap = 0;
        slv_waits = 0; slv_err = 1'b0;
        req_write = 2'b01; req_addr = {8'hB1, 8'hA0}; req_wdata = {32'h11111111, 32'h22222222};
        req_valid = 2'b11;
        for (int c = 0; c <= 12; c++) begin
            if (c == 12) req_valid = '0;
            #1;
            if (req_ready != '0) begin
                g = -1;
                for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
                grants.push_back(g); gcyc.push_back(c);
                if (psel) overlap++;
            end
            if (rsp_valid != '0) begin
                g = -1;
                for (int k = 0; k < NR; k++) if (rsp_valid[k]) g = k;
                rsps.push_back(g);
            end
            @(posedge pclk); #1;
        end
        total++; if (grants.size() !== 4 || rsps.size() !== 4) begin bad++; $display("FAIL b2b_counts got=%0d/%0d want=4/4", grants.size(), rsps.size()); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d want=0", overlap); end
        for (int k = 0; k < grants.size(); k++) begin
            exp_g = model_pick(2'b11);
            model_last = exp_g;
            total++; if (grants[k] !== exp_g) begin bad++; $display("FAIL b2b_grant%0d got=%0d want=%0d", k, grants[k], exp_g); end
            if (k > 0) begin
                total++; if (gcyc[k] - gcyc[k-1] !== 3) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=3", k, gcyc[k] - gcyc[k-1]); end
            end
            if (k < rsps.size()) begin
                total++; if (rsps[k] !== grants[k]) begin bad++; $display("FAIL b2b_owner%0d got=%0d want=%0d", k, rsps[k], grants[k]); end
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] vm, wv, rdy, rv, erdy; logic [NR*AW-1:0] av; logic [NR*DW-1:0] dv;
        logic [DW-1:0] rd, sd, rdd, edata; logic er, sw, re, eerr; logic [1:0] se; logic [AW-1:0] sa;
        int w, win, lat, acc;
        for (int n = 0; n < 30; n++) begin
            vm = NR'($urandom_range(1, 3)); wv = NR'($urandom);
            av = (NR*AW)'($urandom); dv = {$urandom, $urandom};
            w = $urandom_range(0, 5); rd = $urandom; er = 1'($urandom_range(0, 1));
            win = model_pick(vm);
            erdy = '0; erdy[win] = 1'b1;
            eerr = (w >= TO) ? 1'b1 : er;
            edata = ((w >= TO) || wv[win]) ? '0 : rd;
            drive_xfer(vm, wv, av, dv, w, rd, er, rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
            model_last = win;
            total++; if (rdy !== erdy) begin bad++; $display("FAIL rnd%0d_grant got=%b want=%b", n, rdy, erdy); end
            total++; if ({sa, sw} !== {av[win*AW +: AW], wv[win]}) begin bad++; $display("FAIL rnd%0d_setup got=%h want=%h", n, {sa, sw}, {av[win*AW +: AW], wv[win]}); end
            total++; if (lat !== exp_lat(w)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, exp_lat(w)); end
            total++; if (rv !== erdy) begin bad++; $display("FAIL rnd%0d_owner got=%b want=%b", n, rv, erdy); end
            total++; if ({re, rdd} !== {eerr, edata}) begin bad++; $display("FAIL rnd%0d_rsp got=%h want=%h", n, {re, rdd}, {eerr, edata}); end
        end
        slv_waits = 0; slv_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] rdy, rv; int lat, acc; logic [1:0] se; logic [AW-1:0] sa;
        logic sw, re; logic [DW-1:0] sd, rdd; int spurious;
        slv_waits = 1000;
        req_write = 2'b00; req_addr = {8'h00, 8'h7C};
        req_valid = 2'b01;
        @(posedge pclk); #1;
        req_valid = '0;
        @(posedge pclk); #1;
        @(posedge pclk); #2;
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL mid_pre_access got=%b want=11", {psel, penable}); end
        preset = 1'b1;
        #1;
        total++; if ({psel, penable, rsp_valid} !== 4'b0000) begin bad++; $display("FAIL mid_async_drop got=%b want=0000", {psel, penable, rsp_valid}); end
        slv_waits = 0;
        spurious = 0;
        repeat (2) begin
            @(posedge pclk); #1;
            if (rsp_valid != '0) spurious++;
        end
        preset = 1'b0;
        model_last = NR - 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge pclk); #1;
            if (rsp_valid != '0) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", spurious); end
        drive_xfer(2'b11, 2'b11, {8'h91, 8'h90}, {32'h9, 32'h8}, 0, 32'h0, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        total++; if ({rdy, sa} !== {2'b01, 8'h90}) begin bad++; $display("FAIL mid_first_grant got=%h want=%h", {rdy, sa}, {2'b01, 8'h90}); end
        drive_xfer(2'b11, 2'b11, {8'h91, 8'h90}, {32'h9, 32'h8}, 0, 32'h0, 1'b0,
                   rdy, lat, acc, se, sa, sw, sd, rv, rdd, re);
        total++; if ({rdy, rv} !== 4'b1010) begin bad++; $display("FAIL mid_second_grant got=%b want=1010", {rdy, rv}); end
    endtask

    initial begin
        test_reset();
        @(posedge pclk); #1;
        test_single_write();
        test_read_wait();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
